tt_sweep_reader: RTL and testbench

TT_SWEEP_READER -- requirements
Module: tt_sweep_reader

---
 rtl/tt_sweep_reader.sv | 126 ++++++++++++
 tb/tb_tt_sweep_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_reader.sv
// Sweeps every input vector of an N_IN-input combinational function, captures its
// truth table, then streams the table out as bytes over a valid/ready handshake.
module tt_sweep_reader #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] x_out,
  input  logic            y_in,
  output logic [7:0]      tt_data,
  output logic            tt_valid,
  input  logic            tt_ready,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_count
);

  localparam int              TT_BITS     = 2 ** N_IN;
  localparam int              N_BYTES     = TT_BITS / 8;
  localparam int              BW          = (N_IN > 3) ? N_IN - 3 : 1;
  localparam logic [BW-1:0]   LAST_BYTE   = BW'(N_BYTES - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE);
  localparam logic [N_IN-1:0] X_LAST      = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, STREAM, FIN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N_IN-1:0]     r_x;
  logic [3:0]          r_settle;
  logic [TT_BITS-1:0]  r_tt;
  logic [N_IN:0]       r_ones;
  logic [BW-1:0]       r_byte;
  logic                w_sample;
  logic                w_last_vec;
  logic                w_last_byte;
  logic [N_IN-1:0]     w_base;

  // The last edge of each settle window is the only one that samples y_in.
  assign w_sample    = (r_state == SWEEP) && (r_settle == SETTLE_LAST);
  assign w_last_vec  = (r_x == X_LAST);
  assign w_last_byte = (r_byte == LAST_BYTE);
  assign w_base      = N_IN'({r_byte, 3'b000});

  assign x_out      = r_x;
  assign ones_count = r_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    tt_valid     = 1'b0;
    tt_data      = 8'h00;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = SWEEP;
      end
      SWEEP: begin
        if (w_sample && w_last_vec) w_state_next = STREAM;
      end
      STREAM: begin
        tt_valid = 1'b1;
        tt_data  = r_tt[w_base +: 8];
        if (tt_ready && w_last_byte) w_state_next = FIN;
      end
      FIN: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_settle <= '0;
      r_tt     <= '0;
      r_ones   <= '0;
      r_byte   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x      <= '0;
            r_settle <= '0;
            r_tt     <= '0;
            r_ones   <= '0;
            r_byte   <= '0;
          end
        end
        SWEEP: begin
          if (w_sample) begin
            r_tt[r_x] <= y_in;
            r_ones    <= r_ones + {{N_IN{1'b0}}, y_in};
            r_settle  <= '0;
            // x_out parks at all-ones for the stream instead of wrapping.
            if (w_last_vec) begin
              r_byte <= '0;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        STREAM: begin
          if (tt_ready && !w_last_byte) r_byte <= r_byte + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Randomised bench for tt_sweep_reader: each sweep is compared against a truth table
// the bench chose up front, plus a SETTLE=3 instance fed a delayed function.
module tb_tt_sweep_reader;

  localparam int NB = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [6:0]   x_out;
  logic         y_in;
  logic [7:0]   tt_data;
  logic         tt_valid;
  logic         tt_ready;
  logic         busy;
  logic         done;
  logic [7:0]   ones_count;

  logic         start3;
  logic [6:0]   x3;
  logic         y3;
  logic [7:0]   d3;
  logic         v3;
  logic         r3 = 1'b1;
  logic         busy3;
  logic         done3;
  logic [7:0]   ones3;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] tbl = '0;
  logic         glitch_en = 1'b0;
  logic         noise = 1'b0;
  logic [6:0]   x_prev = '0;
  logic [2:0]   hist = '0;

  tt_sweep_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_out(x_out), .y_in(y_in),
    .tt_data(tt_data), .tt_valid(tt_valid), .tt_ready(tt_ready),
    .busy(busy), .done(done), .ones_count(ones_count)
  );

  tt_sweep_reader #(.N_IN(7), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .x_out(x3), .y_in(y3),
    .tt_data(d3), .tt_valid(v3), .tt_ready(r3),
    .busy(busy3), .done(done3), .ones_count(ones3)
  );

  always #5 clk = ~clk;

  // The function under test is a lookup table; noise only lands in the first
  // cycle after x_out changes, well before the sampling edge.
  assign y_in = tbl[x_out] ^ noise;
  assign y3   = hist[2];

  always @(negedge clk) begin
    noise  <= (glitch_en && (x_out != x_prev)) ? 1'($urandom_range(0, 1)) : 1'b0;
    x_prev <= x_out;
    hist   <= {hist[1:0], x3[0]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [127:0] t, input int k);
    return t[8*k +: 8];
  endfunction

  // ready_mode: 0 = always ready, 1 = random ready, 2 = five-cycle stall on byte 2.
  task automatic run_sweep(input string name, input int ready_mode, input bit busy_start,
                           input bit fin_start);
    int           cnt = 0;
    int           k = 0;
    int           guard = 0;
    int           stall_left = 5;
    bit           rdy;
    logic [127:0] t;
    t = tbl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!tt_valid && cnt < 2000) begin
      cnt++;
      tt_ready = 1'($urandom_range(0, 1));
      start    = busy_start && (cnt == 100);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq({name, "/sweep_cycles"}, cnt, 256);
    check_eq({name, "/x_stream"}, 32'(x_out), 32'h7F);
    while (k < NB && guard < 1000) begin
      check_eq({name, "/valid"}, 32'(tt_valid), 1);
      check_eq({name, "/data"}, 32'(tt_data), 32'(exp_byte(t, k)));
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (k == 2 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      tt_ready = rdy;
      start    = busy_start && (guard == 4);
      @(negedge clk);
      if (rdy) k++;
      guard++;
    end
    start    = 1'b0;
    tt_ready = 1'($urandom_range(0, 1));
    check_eq({name, "/bytes_sent"}, k, NB);
    if (ready_mode == 0) check_eq({name, "/back_to_back"}, guard, NB);
    check_eq({name, "/fin_done"}, 32'(done), 1);
    check_eq({name, "/fin_valid"}, 32'(tt_valid), 0);
    start = fin_start;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, "/idle_busy"}, 32'(busy), 0);
    check_eq({name, "/idle_done"}, 32'(done), 0);
    check_eq({name, "/ones"}, 32'(ones_count), $countones(t));
    tt_ready = 1'b0;
    $display("run %s: sweep=%0d cycles, stream=%0d cycles, ones=%0d", name, cnt, guard,
             ones_count);
  endtask

  task automatic reset_mid_sweep();
    int guard = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (x_out != 7'h40 && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    check_eq("rst/reached_x40", 32'(x_out), 32'h40);
    rst_n = 1'b0;
    #1;
    check_eq("rst/busy", 32'(busy), 0);
    check_eq("rst/valid", 32'(tt_valid), 0);
    check_eq("rst/x_out", 32'(x_out), 0);
    check_eq("rst/ones", 32'(ones_count), 0);
    check_eq("rst/data", 32'(tt_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("rst/idle_busy", 32'(busy), 0);
      check_eq("rst/idle_valid", 32'(tt_valid), 0);
    end
    $display("run reset_mid_sweep: reset applied at x_out=0x40");
  endtask

  initial begin
    int cnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    start3   = 1'b0;
    tt_ready = 1'b0;
    #2;
    check_eq("reset/x_out", 32'(x_out), 0);
    check_eq("reset/data", 32'(tt_data), 0);
    check_eq("reset/valid", 32'(tt_valid), 0);
    check_eq("reset/busy", 32'(busy), 0);
    check_eq("reset/done", 32'(done), 0);
    check_eq("reset/ones", 32'(ones_count), 0);
    check_eq("reset/busy3", 32'(busy3), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tbl = '0;
    run_sweep("zero", 0, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) tbl[i] = i[0];
    run_sweep("xbit0", 0, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) tbl[i] = (i == 127);
    run_sweep("onehot", 1, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) tbl[i] = i[3];
    run_sweep("xbit3_stall", 2, 1'b0, 1'b1);

    glitch_en = 1'b1;
    tbl = {$urandom, $urandom, $urandom, $urandom};
    run_sweep("busy_start", 1, 1'b1, 1'b0);
    reset_mid_sweep();
    tbl = {$urandom, $urandom, $urandom, $urandom};
    run_sweep("post_reset", 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      tbl = {$urandom, $urandom, $urandom, $urandom};
      run_sweep("random", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    glitch_en = 1'b0;

    // SETTLE=3 instance: y3 lags x3[0] by two cycles, still settled at the sample.
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cnt = 0;
    while (!v3 && cnt < 4000) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("s3/sweep_cycles", cnt, 512);
    for (int k = 0; k < NB; k++) begin
      check_eq("s3/valid", 32'(v3), 1);
      check_eq("s3/data", 32'(d3), 32'hAA);
      @(negedge clk);
    end
    check_eq("s3/done", 32'(done3), 1);
    check_eq("s3/ones", 32'(ones3), 64);
    $display("run settle3: sweep=%0d cycles, ones=%0d", cnt, ones3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
